// File: rtl/mips_pkg.sv
// mips_pkg: state, opcode/funct and datapath select encodings shared by control and datapath
package mips_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_J    = 2'd2;
  localparam logic [1:0] NPC_JR   = 2'd3;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_HI16 = 2'd2;
  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_DM    = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;
  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;
  typedef struct packed {
    logic rtype_alu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic illegal;
  } instr_class_t;
endpackage

// File: rtl/mips_instr_decode.sv
// mips_instr_decode: classifies the latched instruction word into one-hot instruction classes
module mips_instr_decode
  import mips_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_t cls
);
  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;
  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_bits = ^instr[25:6];
  always_comb begin
    cls = '0;
    cls.rtype_alu = op == OP_RTYPE && (fn == FN_ADDU || fn == FN_SUBU);
    cls.jr = op == OP_RTYPE && fn == FN_JR;
    cls.ori = op == OP_ORI;
    cls.lui = op == OP_LUI;
    cls.lw = op == OP_LW;
    cls.sw = op == OP_SW;
    cls.beq = op == OP_BEQ;
    cls.j = op == OP_J;
    cls.jal = op == OP_JAL;
    cls.illegal = op == OP_RTYPE ? !(fn == FN_ADDU || fn == FN_SUBU || fn == FN_JR)
                : !(op inside {OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL});
  end
endmodule

// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm: multi-cycle MIPS control sequencer driving datapath enables and selects
module mips_ctrl_fsm
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  output logic        irwr,
  output logic        pcwr,
  output logic [1:0]  npc_op,
  output logic        rfwr,
  output logic [1:0]  regdst,
  output logic        alusrc,
  output logic [2:0]  aluop,
  output logic [1:0]  extop,
  output logic        dmwr,
  output logic [1:0]  wbsel,
  output logic        illegal,
  output logic [2:0]  state
);
  state_t       state_q, state_d;
  instr_class_t c;
  logic         fe, de, ex, me, wb, hold, is_sub;
  mips_instr_decode u_dec (
    .instr(instr),
    .cls  (c)
  );
  assign fe = state_q == S_FETCH;
  assign de = state_q == S_DECODE;
  assign ex = state_q == S_EXE;
  assign me = state_q == S_MEM;
  assign wb = state_q == S_WB;
  assign hold = ex | me | wb;
  assign is_sub = c.rtype_alu && instr[5:0] == FN_SUBU;
  always_comb begin
    state_d = fe ? S_DECODE
            : de ? ((c.j | c.jal | c.jr | c.illegal) ? S_FETCH : S_EXE)
            : ex ? (c.beq ? S_FETCH : (c.lw | c.sw) ? S_MEM : S_WB)
            : me ? (c.lw ? S_WB : S_FETCH)
            : S_FETCH;
  end
  always_ff @(posedge clk) begin
    state_q <= !rst ? S_FETCH : state_d;
  end
  assign state = state_q;
  // enables are gated by rst so nothing writes while reset is held
  assign irwr = rst & fe;
  assign pcwr = rst & (fe | (de & (c.j | c.jal | c.jr)) | (ex & c.beq & zero));
  assign rfwr = rst & ((de & c.jal) | wb);
  assign dmwr = rst & me & c.sw;
  assign illegal = rst & de & c.illegal;
  assign npc_op = (de & (c.j | c.jal)) ? NPC_J
                : (de & c.jr) ? NPC_JR
                : (ex & c.beq) ? NPC_BR
                : NPC_PC4;
  assign regdst = (de & c.jal) ? RD_RA : (wb & c.rtype_alu) ? RD_RD : RD_RT;
  assign wbsel = (de & c.jal) ? WB_PC4 : (wb & c.lw) ? WB_DM : WB_ALU;
  assign alusrc = hold & (c.ori | c.lui | c.lw | c.sw);
  assign aluop = !hold ? ALU_ADD
               : (c.beq | is_sub) ? ALU_SUB
               : c.ori ? ALU_OR
               : c.lui ? ALU_LUI
               : ALU_ADD;
  assign extop = !hold ? EXT_ZERO
               : (c.lw | c.sw) ? EXT_SIGN
               : c.lui ? EXT_HI16
               : EXT_ZERO;
endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// tb_mips_ctrl_fsm: directed per-cycle checks of the multi-cycle control sequencer
module tb_mips_ctrl_fsm;
  logic        clk = 1'b0, rst = 1'b0, zero = 1'b0;
  logic [31:0] instr = '0;
  logic        irwr, pcwr, rfwr, alusrc, dmwr, illegal;
  logic [1:0]  npc_op, regdst, extop, wbsel;
  logic [2:0]  aluop, state;
  logic [19:0] obs, F, D0;
  int          checks = 0, failures = 0;
  mips_ctrl_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .irwr(irwr), .pcwr(pcwr), .npc_op(npc_op), .rfwr(rfwr),
    .regdst(regdst), .alusrc(alusrc), .aluop(aluop), .extop(extop),
    .dmwr(dmwr), .wbsel(wbsel), .illegal(illegal), .state(state)
  );
  always #5 clk = ~clk;
  assign obs = {irwr, pcwr, npc_op, rfwr, regdst, alusrc, aluop, extop, dmwr, wbsel, illegal, state};
  function automatic logic [19:0] v(input int ir, input int pc, input int np, input int rf,
                                    input int rd, input int as, input int ao, input int eo,
                                    input int dm, input int ws, input int il, input int st);
    return {ir[0], pc[0], np[1:0], rf[0], rd[1:0], as[0], ao[2:0], eo[1:0], dm[0], ws[1:0], il[0], st[2:0]};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      instr = $urandom;
      tick();
      checks++;
      if (obs !== 20'h0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d got=%h exp=%h", k, obs, 20'h0);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== F) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs, F);
    end
  endtask
  task automatic test_rtype;
    logic [31:0] ins [8];
    logic [19:0] e [8];
    ins = '{32'h00221821, 32'h00221821, 32'h00221821, 32'h00221821,
            32'h00221823, 32'h00221823, 32'h00221823, 32'h00221823};
    e = '{F, D0, v(0,0,0,0,0,0,0,0,0,0,0,2), v(0,0,0,1,1,0,0,0,0,0,0,4),
          F, D0, v(0,0,0,0,0,0,1,0,0,0,0,2), v(0,0,0,1,1,0,1,0,0,0,0,4)};
    for (int k = 0; k < 8; k++) begin
      instr = ins[k];
      #1;
      checks++;
      if (obs !== e[k]) begin
        failures++;
        $display("FAIL rtype cyc%0d got=%h exp=%h", k, obs, e[k]);
      end
      tick();
    end
  endtask
  task automatic test_imm;
    logic [31:0] ins [8];
    logic [19:0] e [8];
    ins = '{32'h34220005, 32'h34220005, 32'h34220005, 32'h34220005,
            32'h3C021234, 32'h3C021234, 32'h3C021234, 32'h3C021234};
    e = '{F, D0, v(0,0,0,0,0,1,2,0,0,0,0,2), v(0,0,0,1,0,1,2,0,0,0,0,4),
          F, D0, v(0,0,0,0,0,1,3,2,0,0,0,2), v(0,0,0,1,0,1,3,2,0,0,0,4)};
    for (int k = 0; k < 8; k++) begin
      instr = ins[k];
      #1;
      checks++;
      if (obs !== e[k]) begin
        failures++;
        $display("FAIL imm cyc%0d got=%h exp=%h", k, obs, e[k]);
      end
      tick();
    end
  endtask
  task automatic test_mem;
    logic [31:0] ins [9];
    logic [19:0] e [9];
    ins = '{32'h8C430004, 32'h8C430004, 32'h8C430004, 32'h8C430004, 32'h8C430004,
            32'hAC430004, 32'hAC430004, 32'hAC430004, 32'hAC430004};
    e = '{F, D0, v(0,0,0,0,0,1,0,1,0,0,0,2), v(0,0,0,0,0,1,0,1,0,0,0,3), v(0,0,0,1,0,1,0,1,0,1,0,4),
          F, D0, v(0,0,0,0,0,1,0,1,0,0,0,2), v(0,0,0,0,0,1,0,1,1,0,0,3)};
    for (int k = 0; k < 9; k++) begin
      instr = ins[k];
      #1;
      checks++;
      if (obs !== e[k]) begin
        failures++;
        $display("FAIL mem cyc%0d got=%h exp=%h", k, obs, e[k]);
      end
      tick();
    end
  endtask
  task automatic test_branch;
    logic        z [6];
    logic [19:0] e [6];
    z = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    e = '{F, D0, v(0,1,1,0,0,0,1,0,0,0,0,2),
          F, D0, v(0,0,1,0,0,0,1,0,0,0,0,2)};
    instr = 32'h10220003;
    for (int k = 0; k < 6; k++) begin
      zero = z[k];
      #1;
      checks++;
      if (obs !== e[k]) begin
        failures++;
        $display("FAIL beq cyc%0d got=%h exp=%h", k, obs, e[k]);
      end
      tick();
    end
    zero = 1'b0;
  endtask
  task automatic test_jump;
    logic [31:0] ins [8];
    logic [19:0] e [8];
    ins = '{32'h08000010, 32'h08000010, 32'h0C000010, 32'h0C000010,
            32'h03E00008, 32'h03E00008, 32'hFC000000, 32'hFC000000};
    e = '{F, v(0,1,2,0,0,0,0,0,0,0,0,1),
          F, v(0,1,2,1,2,0,0,0,0,2,0,1),
          F, v(0,1,3,0,0,0,0,0,0,0,0,1),
          F, v(0,0,0,0,0,0,0,0,0,0,1,1)};
    for (int k = 0; k < 8; k++) begin
      instr = ins[k];
      zero = k[0];
      #1;
      checks++;
      if (obs !== e[k]) begin
        failures++;
        $display("FAIL jump cyc%0d got=%h exp=%h", k, obs, e[k]);
      end
      tick();
    end
    zero = 1'b0;
  endtask
  task automatic test_reset_mid;
    logic [19:0] e [4];
    e = '{F, D0, v(0,0,0,0,0,1,0,1,0,0,0,2), v(0,0,0,0,0,1,0,1,0,0,0,3)};
    instr = 32'h8C430004;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (obs !== e[k]) begin
        failures++;
        $display("FAIL reset_mid_pre cyc%0d got=%h exp=%h", k, obs, e[k]);
      end
      if (k == 3) rst = 1'b0;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs !== 20'h0) begin
        failures++;
        $display("FAIL reset_mid_hold cyc%0d got=%h exp=%h", k, obs, 20'h0);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== F) begin
      failures++;
      $display("FAIL reset_mid_release got=%h exp=%h", obs, F);
    end
  endtask
  initial begin
    F = v(1,1,0,0,0,0,0,0,0,0,0,0);
    D0 = v(0,0,0,0,0,0,0,0,0,0,0,1);
    test_reset();
    test_rtype();
    test_imm();
    test_mem();
    test_branch();
    test_jump();
    test_reset_mid();
    test_rtype();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
